// File: rtl/rom_burst_reader.sv
// Burst address sequencer for the 32x8 banked ROM. It streams registered ROM
// words downstream one beat per cycle, honours backpressure, and pulses done_o.
module rom_burst_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_last_o,
  output logic              done_o,
  output logic              busy_o
);

  // state  | meaning
  // IDLE   | waiting for a burst request, req_ready_o high
  // STREAM | presenting ROM addresses, loading the output stage
  // DRAIN  | all words loaded, holding the final beat until accepted
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              load;
  logic              accept_req;
  logic              drain_accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    accept_req   = 1'b0;
    drain_accept = 1'b0;
    req_ready_o  = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept_req = 1'b1;
          state_d    = (req_len_i == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        // Reload in the same cycle the held beat is taken: 1 beat/cycle.
        load = (!rd_valid_o || rd_ready_i) && (rem_q != '0);
        if (load && rem_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (rd_ready_i) begin
          drain_accept = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      rem_q      <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_addr_o  <= '0;
      rd_last_o  <= 1'b0;
    end else begin
      if (accept_req) begin
        addr_q <= req_addr_i;
        rem_q  <= req_len_i;
      end
      if (load) begin
        rd_data_o  <= rom_data_i;
        rd_addr_o  <= addr_q;
        rd_valid_o <= 1'b1;
        rd_last_o  <= (rem_q == LEN_W'(1));
        addr_q     <= addr_q + ADDR_W'(1);
        rem_q      <= rem_q - LEN_W'(1);
      end
      if (drain_accept) begin
        rd_valid_o <= 1'b0;
        rd_last_o  <= 1'b0;
      end
    end
  end

  assign rom_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: table of bursts with hand-computed
// beats, plus sequences for mid-burst reset and a request held while busy.
module tb_rom_burst_reader;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [4:0] req_addr_i = '0;
  logic [5:0] req_len_i = '0;
  logic [4:0] rom_addr_o;
  logic [7:0] rom_data_i;
  logic       rd_valid_o;
  logic       rd_ready_i = 1'b0;
  logic [7:0] rd_data_o;
  logic [4:0] rd_addr_o;
  logic       rd_last_o;
  logic       done_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  rom_burst_reader dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_last_o(rd_last_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  // Banked ROM: each word holds the low three address bits.
  assign rom_data_i = {5'b0, rom_addr_o[2:0]};

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0]      addr;
    logic [5:0]      len;
    logic            tog;
    logic [7:0][4:0] ea;   // expected rd_addr_o per beat, beat 0 rightmost
    logic [7:0][7:0] ed;   // expected rd_data_o per beat, beat 0 rightmost
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered at the negedge of C+1 (cycle after the request handshake).
  task automatic collect(input int n, input logic tog,
                         input logic [7:0][4:0] ea, input logic [7:0][7:0] ed);
    int beat = 0;
    int cyc = 0;
    bit stalled = 0, stall_bad = 0, early_done = 0, ready_hi = 0;
    logic [7:0] hd;
    logic [4:0] ha;
    logic       hl;
    while (beat < n && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      rd_ready_i = tog ? (cyc % 2 == 0) : 1'b1;
      if (cyc == 1) check("first_valid_c2", int'(rd_valid_o), 1);
      if (done_o) early_done = 1;
      if (req_ready_o) ready_hi = 1;
      if (stalled && (!rd_valid_o || rd_data_o != hd || rd_addr_o != ha || rd_last_o != hl))
        stall_bad = 1;
      stalled = rd_valid_o && !rd_ready_i;
      hd = rd_data_o; ha = rd_addr_o; hl = rd_last_o;
      if (rd_valid_o && rd_ready_i) begin
        check("beat_addr", int'(rd_addr_o), int'(ea[beat]));
        check("beat_data", int'(rd_data_o), int'(ed[beat]));
        check("beat_last", int'(rd_last_o), (beat == n - 1) ? 1 : 0);
        beat++;
      end
    end
    check("beat_count", beat, n);
    check("no_early_done", int'(early_done), 0);
    check("req_ready_low_busy", int'(ready_hi), 0);
    if (tog) check("stall_stable", int'(stall_bad), 0);
    @(negedge clk_i);
    check("done_pulse", int'(done_o), 1);
    check("valid_low_at_done", int'(rd_valid_o), 0);
    check("last_low_at_done", int'(rd_last_o), 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = v.addr; req_len_i = v.len;
    check("req_ready_idle", int'(req_ready_o), 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rd_ready_i = v.tog ? 1'b0 : 1'b1;
    check("busy_c1", int'(busy_o), 1);
    if (v.len == 0) begin
      check("len0_done_c1", int'(done_o), 1);
      check("len0_no_valid", int'(rd_valid_o), 0);
      @(negedge clk_i);
      check("len0_ready_c2", int'(req_ready_o), 1);
      check("len0_done_once", int'(done_o), 0);
      check("len0_no_valid_c2", int'(rd_valid_o), 0);
    end else begin
      check("rom_addr_c1", int'(rom_addr_o), int'(v.addr));
      check("no_valid_c1", int'(rd_valid_o), 0);
      collect(int'(v.len), v.tog, v.ea, v.ed);
      @(negedge clk_i);
      check("done_once", int'(done_o), 0);
      check("idle_busy", int'(busy_o), 0);
      check("idle_ready", int'(req_ready_o), 1);
    end
  endtask

  initial begin
    vec_t v;
    bit   saw_done;

    vecs[0] = '{addr: 5'd0, len: 6'd8, tog: 1'b0,
                ea: {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0},
                ed: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}};
    vecs[1] = '{addr: 5'd30, len: 6'd4, tog: 1'b0,
                ea: {5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd31, 5'd30},
                ed: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd7, 8'd6}};
    vecs[2] = '{addr: 5'd13, len: 6'd3, tog: 1'b1,
                ea: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd15, 5'd14, 5'd13},
                ed: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd6, 8'd5}};
    vecs[3] = '{addr: 5'd9, len: 6'd0, tog: 1'b0, ea: '0, ed: '0};
    vecs[4] = '{addr: 5'd5, len: 6'd1, tog: 1'b0,
                ea: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5},
                ed: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5}};

    repeat (3) @(negedge clk_i);
    check("rst_valid", int'(rd_valid_o), 0);
    check("rst_ready", int'(req_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_rom_addr", int'(rom_addr_o), 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset after two accepted beats of an 8-beat burst.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 5'd0; req_len_i = 6'd8;
    @(negedge clk_i);
    req_valid_i = 1'b0; rd_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("abort_valid", int'(rd_valid_o), 0);
    check("abort_data", int'(rd_data_o), 0);
    check("abort_addr", int'(rd_addr_o), 0);
    check("abort_last", int'(rd_last_o), 0);
    check("abort_rom_addr", int'(rom_addr_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_ready", int'(req_ready_o), 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    saw_done = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1;
    end
    check("abort_no_done", int'(saw_done), 0);
    v = '{addr: 5'd8, len: 6'd2, tog: 1'b0,
          ea: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd8},
          ed: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0}};
    run_vec(v);

    // Second request held valid throughout a running burst.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 5'd4; req_len_i = 6'd3;
    check("held_first_ready", int'(req_ready_o), 1);
    @(negedge clk_i);
    req_addr_i = 5'd16; req_len_i = 6'd2; rd_ready_i = 1'b1;
    check("held_busy", int'(busy_o), 1);
    collect(3, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd5, 5'd4},
            {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd5, 8'd4});
    check("held_ready_at_done", int'(req_ready_o), 0);
    @(negedge clk_i);
    check("held_ready_after_done", int'(req_ready_o), 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("held_rom_addr", int'(rom_addr_o), 16);
    collect(2, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd17, 5'd16},
            {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0});
    @(negedge clk_i);
    check("final_idle", int'(busy_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Upstream address sequencer and read-stream controller for the 32x8 banked ROM.
- Accepts a burst request (start address, length) on a valid/ready handshake.
- Drives the ROM address one word per cycle and registers the combinational ROM output into a one-deep output stage.
- Presents data downstream on a valid/ready stream with backpressure, a last-beat flag and a done pulse.

Parameters:
ADDR_W, 5, ROM address width (depth 2**ADDR_W = 32)
DATA_W, 8, ROM word width
LEN_W, ADDR_W+1, burst length field width (0..63 beats)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  burst request valid
req_ready_o  output  1  request accepted when high with req_valid_i
req_addr_i  input  ADDR_W  burst start address
req_len_i  input  LEN_W  burst length in beats
rom_addr_o  output  ADDR_W  address to ROM; ROM returns data combinationally
rom_data_i  input  DATA_W  ROM read data for rom_addr_o
rd_valid_o  output  1  output beat valid
rd_ready_i  input  1  downstream accepts beat
rd_data_o  output  DATA_W  registered ROM data
rd_addr_o  output  ADDR_W  address tag of rd_data_o
rd_last_o  output  1  final beat of burst
done_o  output  1  one-cycle pulse at burst completion
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: state IDLE; rd_valid_o=0, rd_data_o=0, rd_addr_o=0, rd_last_o=0, rom_addr_o=0, done_o=0, busy_o=0; req_ready_o=1 (decoded from IDLE).
- States:
  - IDLE: req_ready_o=1. On handshake, latch req_addr_i into the address counter and req_len_i into the remaining counter. Go to DONE if len==0, else STREAM.
  - STREAM: rom_addr_o = address counter. Load condition: (!rd_valid_o || rd_ready_i) && remaining>0. On each load:
    - rd_data_o<=rom_data_i, rd_addr_o<=rom_addr_o, rd_valid_o<=1;
    - rd_last_o<=(remaining==1);
    - address counter +1 modulo 2**ADDR_W (31 wraps to 0);
    - remaining -1.
    - On the last load, go to DRAIN.
  - DRAIN: no further loads; hold the last beat until rd_ready_i. On that handshake, clear rd_valid_o and rd_last_o and go to DONE.
  - DONE: done_o=1 for exactly this one cycle; then IDLE.
- Output register handling:
  - When the last beat is accepted in the same cycle no new load happens, rd_valid_o falls.
  - Mid-burst, accept and reload occur in the same cycle, giving 1 beat/cycle throughput with rd_ready_i held high.
- Latency: request handshake in cycle C, first rom_addr_o in C+1, first rd_valid_o in C+2. done_o is asserted the cycle after the last-beat handshake.
- Stall: while rd_valid_o && !rd_ready_i:
  - rd_data_o, rd_addr_o and rd_last_o are held stable;
  - rom_addr_o and the counters are held;
  - no beat is dropped or duplicated.
- Request handling:
  - req_ready_o=0 in STREAM/DRAIN/DONE, so requests are ignored (not queued) while busy.
  - A new request is accepted in IDLE at the earliest, i.e. the cycle after done_o.
- Length rules:
  - Lengths above 32 are legal; addresses keep wrapping, so words re-read in order.
  - len==0 produces no beats, only a done_o pulse in C+1.
- rom_addr_o holds its last value in IDLE/DRAIN/DONE.
- Reset asserted mid-burst aborts immediately to reset values; no done_o is issued for the aborted burst.

Test Plan:
1. Reset, then request addr=0 len=8 with rd_ready_i=1 -> first rd_valid_o in C+2. Eight consecutive beats, rd_addr_o 0..7, rd_data_o 0..7 (bank pattern = addr[2:0]). rd_last_o on beat 8 only; done_o one cycle after the beat-8 handshake; busy_o low afterwards.
2. Request addr=30 len=4 -> rd_addr_o 30,31,0,1; rd_data_o 6,7,0,1; rd_last_o with addr 1.
3. Request addr=13 len=3 with rd_ready_i toggling 0/1 every cycle -> exactly three beats, data 5,6,7 and addresses 13,14,15. rd_data_o and rd_addr_o stable across every stalled cycle.
4. Request len=0 at addr=9 -> rd_valid_o never asserts; done_o pulses in C+1; req_ready_o high again in C+2.
5. Request addr=0 len=8; drive rst_ni low after 2 accepted beats, then release -> all outputs at reset values, no done_o. A following request addr=8 len=2 returns data 0,1 normally.
6. Hold req_valid_i=1 with addr=16 len=2 throughout a running burst addr=4 len=3 -> req_ready_o stays 0 until the first burst's done_o. The second request is accepted the cycle after that done_o and returns addresses 16,17.
